// File: rtl/tt_chk_pkg.sv
// Shared types and sizing helpers for the truth-table checker.
package tt_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } chk_state_t;

    function automatic int rows_of(input int n_in);
        return 1 << n_in;
    endfunction

    // One extra bit so the row counter never wraps inside a run.
    function automatic int cnt_w_of(input int n_in);
        return n_in + 1;
    endfunction

    localparam int N_IN_DEFAULT = 3;
    localparam int ROWS         = rows_of(N_IN_DEFAULT);
    localparam int CNT_W        = cnt_w_of(N_IN_DEFAULT);

endpackage

// File: rtl/tt_vec_seq.sv
// Row sequencer: steps the applied vector once every DUT_LAT+1 cycles and
// flags the compare cycle and the final row.
module tt_vec_seq
    import tt_chk_pkg::*;
#(
    parameter int N_IN    = 3,
    parameter int DUT_LAT = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            en,
    output logic [N_IN-1:0] vec,
    output logic            cmp,
    output logic            last
);

    localparam int CW     = cnt_w_of(N_IN);
    localparam int ROW_N  = rows_of(N_IN);
    localparam int WAIT_W = (DUT_LAT > 0) ? $clog2(DUT_LAT + 1) : 1;

    logic [CW-1:0]     vec_cnt;
    logic [WAIT_W-1:0] wait_cnt;

    // Settle timer runs down from DUT_LAT; terminal count marks the compare cycle.
    assign cmp  = (wait_cnt == '0);
    assign last = (vec_cnt == CW'(ROW_N - 1));
    assign vec  = vec_cnt[N_IN-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_cnt  <= '0;
            wait_cnt <= WAIT_W'(DUT_LAT);
        end else if (clr) begin
            vec_cnt  <= '0;
            wait_cnt <= WAIT_W'(DUT_LAT);
        end else if (en) begin
            if (cmp) begin
                wait_cnt <= WAIT_W'(DUT_LAT);
                if (!last)
                    vec_cnt <= vec_cnt + CW'(1);
            end else begin
                wait_cnt <= wait_cnt - WAIT_W'(1);
            end
        end
    end

endmodule

// File: rtl/truth_table_checker.sv
// Exhaustive truth-table self-test for a small combinational or pipelined DUT.
// Optional build macro: CHK_STOP_ON_FAIL_EN ends a run at the first mismatching row.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   ST_IDLE | after reset, waiting for start
//   ST_RUN  | applying vectors and comparing against GOLDEN
//   ST_DONE | results held until the next start
module truth_table_checker
    import tt_chk_pkg::*;
#(
    parameter int                     N_IN    = 3,
    parameter logic [(1<<N_IN)-1:0]   GOLDEN  = 8'h13,
    parameter int                     DUT_LAT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  dut_out,
    output logic [N_IN-1:0]       dut_in,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [(1<<N_IN)-1:0]  fail_mask,
    output logic [N_IN:0]         fail_count,
    output logic [N_IN-1:0]       first_fail,
    output logic                  first_fail_vld
);

    localparam int ROW_N = rows_of(N_IN);
    localparam int CW    = cnt_w_of(N_IN);

    chk_state_t      state, state_nxt;
    logic            seq_clr, seq_en;
    logic [N_IN-1:0] vec;
    logic            cmp, last;
    logic            mismatch, stop_now;

    tt_vec_seq #(
        .N_IN    (N_IN),
        .DUT_LAT (DUT_LAT)
    ) u_seq (
        .clk  (clk),
        .rst  (rst),
        .clr  (seq_clr),
        .en   (seq_en),
        .vec  (vec),
        .cmp  (cmp),
        .last (last)
    );

    assign mismatch = (state == ST_RUN) && cmp && (dut_out != GOLDEN[vec]);

`ifdef CHK_STOP_ON_FAIL_EN
    assign stop_now = mismatch;
`else
    assign stop_now = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Holding the sequencer on an early stop keeps dut_in at the failing row.
    always_comb begin
        state_nxt = state;
        seq_clr   = 1'b0;
        seq_en    = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                    seq_clr   = 1'b1;
                end
            end
            ST_RUN: begin
                seq_en = !stop_now;
                if (cmp && (last || stop_now))
                    state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_mask      <= '0;
            fail_count     <= '0;
            first_fail     <= '0;
            first_fail_vld <= 1'b0;
        end else if (seq_clr) begin
            fail_mask      <= '0;
            fail_count     <= '0;
            first_fail     <= '0;
            first_fail_vld <= 1'b0;
        end else if (mismatch) begin
            fail_mask[vec] <= 1'b1;
            if (fail_count != CW'(ROW_N))
                fail_count <= fail_count + CW'(1);
            if (!first_fail_vld) begin
                first_fail     <= vec;
                first_fail_vld <= 1'b1;
            end
        end
    end

    assign dut_in = vec;
    assign busy   = (state == ST_RUN);
    assign done   = (state == ST_DONE);
    assign pass   = done && (fail_count == '0);

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: one zero-latency and one registered DUT model,
// table-driven runs scored through an expectation queue, plus reset and restart sequences.
module tb_truth_table_checker;

    typedef struct {
        int lat;
        int sel;
        int mask;
        int count;
        int first;
        int vld;
        int pass;
        int last_in;
        int busy;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_0, start_1;
    logic       dut_out_0, dut_out_1;
    logic [2:0] dut_in_0, dut_in_1;
    logic       busy_0, busy_1, done_0, done_1, pass_0, pass_1;
    logic [7:0] fail_mask_0, fail_mask_1;
    logic [3:0] fail_count_0, fail_count_1;
    logic [2:0] first_fail_0, first_fail_1;
    logic       first_fail_vld_0, first_fail_vld_1;

    int   sel;
    bit   cur;
    int   cur_ti;
    int   n_chk  = 0;
    int   n_fail = 0;
    vec_t tbl [6];
    vec_t sb_q [$];

    logic       o_busy, o_done, o_pass, o_vld;
    logic [7:0] o_mask;
    logic [3:0] o_count;
    logic [2:0] o_first, o_in;

    always #5 clk = ~clk;

    // sel: 0 correct DUT, 1 faulty function, 2 stuck-at-0, 3 inverted golden
    function automatic logic model_y(input int s, input logic [2:0] x);
        logic [7:0] g;
        g = 8'h13;
        case (s)
            0:       return g[x];
            1:       return (~x[1] & ~x[0]) | (x[2] & ~x[1]);
            2:       return 1'b0;
            default: return ~g[x];
        endcase
    endfunction

    assign dut_out_0 = model_y(sel, dut_in_0);
    always @(posedge clk) dut_out_1 <= model_y(sel, dut_in_1);

    truth_table_checker #(.N_IN(3), .GOLDEN(8'h13), .DUT_LAT(0)) u_lat0 (
        .clk(clk), .rst(rst), .start(start_0), .dut_out(dut_out_0), .dut_in(dut_in_0),
        .busy(busy_0), .done(done_0), .pass(pass_0), .fail_mask(fail_mask_0),
        .fail_count(fail_count_0), .first_fail(first_fail_0), .first_fail_vld(first_fail_vld_0)
    );

    truth_table_checker #(.N_IN(3), .GOLDEN(8'h13), .DUT_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .start(start_1), .dut_out(dut_out_1), .dut_in(dut_in_1),
        .busy(busy_1), .done(done_1), .pass(pass_1), .fail_mask(fail_mask_1),
        .fail_count(fail_count_1), .first_fail(first_fail_1), .first_fail_vld(first_fail_vld_1)
    );

    always_comb begin
        o_busy  = cur ? busy_1           : busy_0;
        o_done  = cur ? done_1           : done_0;
        o_pass  = cur ? pass_1           : pass_0;
        o_vld   = cur ? first_fail_vld_1 : first_fail_vld_0;
        o_mask  = cur ? fail_mask_1      : fail_mask_0;
        o_count = cur ? fail_count_1     : fail_count_0;
        o_first = cur ? first_fail_1     : first_fail_0;
        o_in    = cur ? dut_in_1         : dut_in_0;
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (case %0d): got %0d, expected %0d", name, cur_ti, act, exp);
        end
    endtask

    task automatic drive_start(input logic v);
        if (cur) start_1 = v;
        else     start_0 = v;
    endtask

    // Called on a falling edge; returns on the first falling edge of the run.
    task automatic start_run(input int ti, input logic keep);
        cur_ti = ti;
        cur    = (tbl[ti].lat == 1);
        sel    = tbl[ti].sel;
        sb_q.push_back(tbl[ti]);
        drive_start(1'b1);
        @(negedge clk);
        drive_start(keep);
    endtask

    task automatic wait_check(input bit repulse);
        int   cyc = 0;
        int   k   = 0;
        bit   ok  = 1'b0;
        vec_t e;
        for (int g = 0; g < 200; g++) begin
            if (repulse && k == 1) drive_start(1'b1);
            if (repulse && k == 2) drive_start(1'b0);
            if (o_done) begin
                ok = 1'b1;
                break;
            end
            if (o_busy) cyc++;
            k++;
            @(negedge clk);
        end
        check("run_completed", int'(ok), 1);
        check("scoreboard_nonempty", (sb_q.size() > 0) ? 1 : 0, 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("busy_cycles",    cyc,            e.busy);
            check("busy_after",     int'(o_busy),   0);
            check("fail_mask",      int'(o_mask),   e.mask);
            check("fail_count",     int'(o_count),  e.count);
            check("first_fail",     int'(o_first),  e.first);
            check("first_fail_vld", int'(o_vld),    e.vld);
            check("pass",           int'(o_pass),   e.pass);
            check("dut_in_final",   int'(o_in),     e.last_in);
        end
    endtask

    task automatic check_zero_lat0(input string tag);
        check({tag, "_dut_in"},     int'(dut_in_0),         0);
        check({tag, "_busy"},       int'(busy_0),           0);
        check({tag, "_done"},       int'(done_0),           0);
        check({tag, "_pass"},       int'(pass_0),           0);
        check({tag, "_fail_mask"},  int'(fail_mask_0),      0);
        check({tag, "_fail_count"}, int'(fail_count_0),     0);
        check({tag, "_first_fail"}, int'(first_fail_0),     0);
        check({tag, "_vld"},        int'(first_fail_vld_0), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //        lat sel mask  cnt first vld pass last busy
        tbl[0] = '{0, 0, 8'h00, 0, 0, 0, 1, 7, 8};
        tbl[5] = '{1, 0, 8'h00, 0, 0, 0, 1, 7, 16};
`ifdef CHK_STOP_ON_FAIL_EN
        tbl[1] = '{0, 1, 8'h02, 1, 1, 1, 0, 1, 2};
        tbl[2] = '{1, 1, 8'h02, 1, 1, 1, 0, 1, 4};
        tbl[3] = '{0, 2, 8'h01, 1, 0, 1, 0, 0, 1};
        tbl[4] = '{1, 3, 8'h01, 1, 0, 1, 0, 0, 2};
`else
        tbl[1] = '{0, 1, 8'h22, 2, 1, 1, 0, 7, 8};
        tbl[2] = '{1, 1, 8'h22, 2, 1, 1, 0, 7, 16};
        tbl[3] = '{0, 2, 8'h13, 3, 0, 1, 0, 7, 8};
        tbl[4] = '{1, 3, 8'hFF, 8, 0, 1, 0, 7, 16};
`endif

        rst = 1'b1; start_0 = 1'b0; start_1 = 1'b0; sel = 0; cur = 1'b0; cur_ti = -1;
        repeat (2) @(negedge clk);
        check_zero_lat0("reset");
        check("reset_lat1_busy", int'(busy_1), 0);
        check("reset_lat1_done", int'(done_1), 0);
        check("reset_lat1_in",   int'(dut_in_1), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            start_run(i, 1'b0);
            wait_check(1'b0);
            @(negedge clk);
        end

        // Reset during a run on the zero-latency instance
        cur = 1'b0; sel = 1; cur_ti = 10;
        start_0 = 1'b1;
        @(negedge clk);
        start_0 = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_mask", int'(fail_mask_0), 8'h02);
        #2 rst = 1'b1;
        #1 check_zero_lat0("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start_run(1, 1'b0);
        wait_check(1'b0);

        // Start re-pulsed mid-run, then held high across DONE
        start_run(1, 1'b0);
        wait_check(1'b1);
        start_run(1, 1'b1);
        wait_check(1'b0);
        start_run(1, 1'b0);
        check("rerun_busy",  int'(busy_0),           1);
        check("rerun_done",  int'(done_0),           0);
        check("rerun_mask",  int'(fail_mask_0),      0);
        check("rerun_count", int'(fail_count_0),     0);
        check("rerun_vld",   int'(first_fail_vld_0), 0);
        wait_check(1'b0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
